// File: rtl/vector_norm_engine.sv
// Streams a vector from memory and reduces it to a sum of squares,
// sum of magnitudes or peak magnitude, saturating on overflow.
module vector_norm_engine #(
    parameter int WORD_W = 24,
    parameter int LEN_W  = 8,
    parameter int ADDR_W = 9,
    parameter int ACC_W  = 48
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base,
    input  logic [LEN_W-1:0]  len,
    input  logic [1:0]        mode,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [WORD_W-1:0] rd_data,
    output logic [ACC_W-1:0]  result,
    output logic              ovf,
    output logic [LEN_W-1:0]  count,
    output logic              busy,
    output logic              done,
    output logic [1:0]        state
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        FETCH = 2'b01,
        DRAIN = 2'b10,
        DONE  = 2'b11
    } state_t;

    state_t cur, nxt;

    logic [ADDR_W-1:0]   base_r;
    logic [LEN_W-1:0]    len_r;
    logic [LEN_W-1:0]    idx;
    logic [1:0]          mode_r;
    logic [ACC_W-1:0]    acc;
    logic [ACC_W-1:0]    acc_nxt;
    logic                ovf_nxt;
    logic                pend;
    logic [WORD_W-1:0]   mag;
    logic [2*WORD_W-1:0] sq;
    logic [ACC_W-1:0]    term;
    logic [ACC_W:0]      sum;

    // Unsigned magnitude: the most-negative input maps to 2^(WORD_W-1).
    assign mag  = rd_data[WORD_W-1]
                ? (~rd_data + {{(WORD_W-1){1'b0}}, 1'b1})
                : rd_data;
    assign sq   = {{WORD_W{1'b0}}, mag} * {{WORD_W{1'b0}}, mag};
    assign term = (mode_r == 2'b01) ? ACC_W'(mag) : ACC_W'(sq);
    assign sum  = {1'b0, acc} + {1'b0, term};

    always_comb begin
        acc_nxt = acc;
        ovf_nxt = ovf;
        if (mode_r == 2'b10) begin
            acc_nxt = (ACC_W'(mag) > acc) ? ACC_W'(mag) : acc;
        end else if (ovf || sum[ACC_W]) begin
            acc_nxt = '1;
            ovf_nxt = 1'b1;
        end else begin
            acc_nxt = sum[ACC_W-1:0];
        end
    end

    always_comb begin
        nxt = cur;
        unique case (cur)
            IDLE:  if (start) nxt = (len == '0) ? DONE : FETCH;
            FETCH: if (idx == len_r - LEN_W'(1)) nxt = DRAIN;
            DRAIN: nxt = DONE;
            DONE:  nxt = IDLE;
        endcase
    end

    assign state   = cur;
    assign busy    = (cur != IDLE);
    assign done    = (cur == DONE);
    assign rd_en   = (cur == FETCH);
    assign rd_addr = rd_en ? base_r + ADDR_W'(idx) : '0;

    // pend marks a read issued last cycle whose data is on rd_data now.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur    <= IDLE;
            base_r <= '0;
            len_r  <= '0;
            mode_r <= '0;
            idx    <= '0;
            acc    <= '0;
            result <= '0;
            ovf    <= 1'b0;
            count  <= '0;
            pend   <= 1'b0;
        end else begin
            cur  <= nxt;
            pend <= (cur == FETCH);
            if (cur == IDLE && start) begin
                base_r <= base;
                len_r  <= len;
                mode_r <= mode;
                idx    <= '0;
                acc    <= '0;
                ovf    <= 1'b0;
                count  <= '0;
                if (len == '0) result <= '0;
            end
            if (cur == FETCH) idx <= idx + LEN_W'(1);
            if (pend) begin
                acc   <= acc_nxt;
                ovf   <= ovf_nxt;
                count <= count + LEN_W'(1);
            end
            if (pend && cur == DRAIN) result <= acc_nxt;
        end
    end

endmodule

// File: tb/tb_vector_norm_engine.sv
// Scoreboard bench for vector_norm_engine: directed vectors with
// hand-computed results, plus address, timing and reset checks.
module tb_vector_norm_engine;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [8:0]  base;
    logic [7:0]  len;
    logic [1:0]  mode;
    logic        rd_en;
    logic [8:0]  rd_addr;
    logic [23:0] rd_data;
    logic [47:0] result;
    logic        ovf;
    logic [7:0]  count;
    logic        busy;
    logic        done;
    logic [1:0]  state;

    logic [23:0] mem [512];

    typedef struct packed {
        logic [47:0] res;
        logic        ovf;
        logic [7:0]  cnt;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;

    vector_norm_engine dut (
        .clk(clk), .rst(rst), .start(start), .base(base), .len(len),
        .mode(mode), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .result(result), .ovf(ovf), .count(count), .busy(busy),
        .done(done), .state(state)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rd_data <= mem[rd_addr];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s act=%0h req=%0h", name, act, req);
        end
    endtask

    // Monitor: pops the expected response whenever done is presented.
    always @(negedge clk) begin
        if (!rst && done) begin
            if (sb.size() == 0) begin
                chk("done_unexpected", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                chk("result", result, e.res);
                chk("ovf", ovf, e.ovf);
                chk("count", count, e.cnt);
            end
        end
    end

    task automatic run(input int b, input int n, input int m,
                       input logic [47:0] er, input logic eo,
                       input int poke);
        exp_t x;
        int dc;
        dc = (n == 0) ? 1 : n + 2;
        x.res = er;
        x.ovf = eo;
        x.cnt = n[7:0];
        sb.push_back(x);
        @(negedge clk);
        base  = b[8:0];
        len   = n[7:0];
        mode  = m[1:0];
        start = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= dc + 1; c++) begin
            @(negedge clk);
            start = (c == poke);
            chk("rd_en", rd_en, (c <= n));
            if (c <= n) chk("rd_addr", rd_addr, (b + c - 1) % 512);
            chk("done_cycle", done, (c == dc));
            chk("busy", busy, (c <= dc));
        end
        start = 1'b0;
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        base  = '0;
        len   = '0;
        mode  = '0;
        for (int i = 0; i < 512; i++) mem[i] = '0;
        mem[0]   = 24'd3;
        mem[1]   = -24'sd4;
        mem[2]   = 24'd12;
        mem[10]  = 24'd5;
        mem[11]  = -24'sd9;
        mem[12]  = 24'd7;
        for (int i = 20; i < 25; i++) mem[i] = 24'h800000;
        mem[510] = 24'd100;
        mem[511] = -24'sd2;

        repeat (2) @(negedge clk);
        chk("rst_state", state, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_rd_en", rd_en, 0);
        chk("rst_rd_addr", rd_addr, 0);
        chk("rst_result", result, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_count", count, 0);
        rst = 1'b0;

        run(0, 3, 0, 48'd169, 1'b0, 0);
        run(0, 0, 0, 48'd0, 1'b0, 0);
        run(10, 3, 1, 48'd21, 1'b0, 0);
        run(10, 3, 2, 48'd9, 1'b0, 0);
        run(20, 5, 0, 48'hFFFF_FFFF_FFFF, 1'b1, 0);
        run(0, 3, 3, 48'd169, 1'b0, 0);
        run(20, 1, 2, 48'd8388608, 1'b0, 0);
        run(510, 4, 1, 48'd109, 1'b0, 0);

        // Abandon a long operation with reset in its third cycle.
        @(negedge clk);
        base  = 9'd0;
        len   = 8'd10;
        mode  = 2'b00;
        start = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst = 1'b1;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_rd_en", rd_en, 0);
        chk("mid_rst_result", result, 0);
        chk("mid_rst_state", state, 0);
        chk("mid_rst_count", count, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (15) begin
            @(negedge clk);
            chk("post_rst_idle", busy, 0);
        end

        run(10, 3, 1, 48'd21, 1'b0, 2);
        run(10, 3, 2, 48'd9, 1'b0, 5);
        @(negedge clk);
        chk("start_in_done_ignored", busy, 0);
        chk("result_held", result, 48'd9);

        repeat (3) @(negedge clk);
        chk("sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
